// File: rtl/idli_fetch_ctrl_m.sv
// Instruction fetch sequencer: issues the SQI READ command, address and dummy
// cycles, then streams 16-bit instructions to the decoder as four nibbles each.
module idli_fetch_ctrl_m (
  input  logic        i_dcd_gck,
  input  logic        i_dcd_rst_n,
  input  logic        i_fetch_redirect,
  input  logic [15:0] i_fetch_pc,
  input  logic        i_fetch_stall,
  output logic [15:0] o_fetch_pc,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output logic [3:0]  o_sqi_sio_out,
  output logic        o_sqi_sio_oe,
  input  logic [3:0]  i_sqi_sio_in,
  output logic [3:0]  o_dcd_enc,
  output logic        o_dcd_enc_vld
);

  localparam int unsigned PC_W    = 16;
  localparam int unsigned SEQ_W   = 3;
  localparam int unsigned NIB_W   = 2;
  localparam int unsigned SIO_W   = 4;
  localparam int unsigned ADDR_W  = 24;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GAP   = 3'd1;
  localparam logic [2:0] ST_CMD   = 3'd2;
  localparam logic [2:0] ST_ADDR  = 3'd3;
  localparam logic [2:0] ST_DUMMY = 3'd4;
  localparam logic [2:0] ST_DATA  = 3'd5;
  localparam logic [2:0] ST_PAUSE = 3'd6;

  localparam logic [SEQ_W-1:0] CMD_LAST   = SEQ_W'(1);
  localparam logic [SEQ_W-1:0] ADDR_LAST  = SEQ_W'(5);
  localparam logic [SEQ_W-1:0] DUMMY_LAST = SEQ_W'(1);
  localparam logic [NIB_W-1:0] NIB_LAST   = NIB_W'(3);

  logic [2:0]        state_q, state_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [NIB_W-1:0]  nib_q, nib_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [PC_W-1:0]   pend_pc_q, pend_pc_d;

  logic              cs_n_q, cs_n_d;
  logic              sck_en_q, sck_en_d;
  logic              oe_q, oe_d;
  logic [SIO_W-1:0]  sio_out_q, sio_out_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] byte_addr_d;

  // State register and registered outputs
  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      state_q   <= ST_IDLE;
      seq_q     <= '0;
      nib_q     <= '0;
      pc_q      <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      cs_n_q    <= 1'b1;
      sck_en_q  <= 1'b0;
      oe_q      <= 1'b0;
      sio_out_q <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      nib_q     <= nib_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      cs_n_q    <= cs_n_d;
      sck_en_q  <= sck_en_d;
      oe_q      <= oe_d;
      sio_out_q <= sio_out_d;
      vld_q     <= vld_d;
    end
  end

  // Next state, PC and redirect bookkeeping
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    nib_d     = nib_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (i_fetch_redirect) begin
          pc_d    = i_fetch_pc;
          state_d = ST_CMD;
          seq_d   = '0;
        end
      end
      ST_GAP: begin
        if (i_fetch_redirect) pc_d = i_fetch_pc;
        state_d = ST_CMD;
        seq_d   = '0;
      end
      ST_CMD, ST_ADDR, ST_DUMMY: begin
        if (i_fetch_redirect) begin
          pc_d    = i_fetch_pc;
          state_d = ST_GAP;
        end else if (state_q == ST_CMD && seq_q == CMD_LAST) begin
          state_d = ST_ADDR;
          seq_d   = '0;
        end else if (state_q == ST_ADDR && seq_q == ADDR_LAST) begin
          state_d = ST_DUMMY;
          seq_d   = '0;
        end else if (state_q == ST_DUMMY && seq_q == DUMMY_LAST) begin
          state_d = ST_DATA;
          nib_d   = '0;
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      ST_DATA: begin
        nib_d = nib_q + NIB_W'(1);
        if (nib_q != NIB_LAST) begin
          // Redirects mid-instruction wait until the instruction completes
          if (i_fetch_redirect) begin
            pend_d    = 1'b1;
            pend_pc_d = i_fetch_pc;
          end
        end else if (i_fetch_redirect || pend_q) begin
          pc_d    = i_fetch_redirect ? i_fetch_pc : pend_pc_q;
          pend_d  = 1'b0;
          state_d = ST_GAP;
        end else begin
          pc_d = pc_q + PC_W'(1);
          if (i_fetch_stall) state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (i_fetch_redirect) begin
          pc_d    = i_fetch_pc;
          state_d = ST_GAP;
        end else if (!i_fetch_stall) begin
          state_d = ST_DATA;
          nib_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode of the upcoming state, registered above
  always_comb begin
    cs_n_d      = 1'b1;
    sck_en_d    = 1'b0;
    oe_d        = 1'b0;
    sio_out_d   = '0;
    vld_d       = 1'b0;
    byte_addr_d = {7'b0, pc_d, 1'b0};
    case (state_d)
      ST_CMD: begin
        cs_n_d    = 1'b0;
        sck_en_d  = 1'b1;
        oe_d      = 1'b1;
        sio_out_d = (seq_d == '0) ? 4'h0 : 4'h3;
      end
      ST_ADDR: begin
        cs_n_d   = 1'b0;
        sck_en_d = 1'b1;
        oe_d     = 1'b1;
        case (seq_d)
          3'd0:    sio_out_d = byte_addr_d[23:20];
          3'd1:    sio_out_d = byte_addr_d[19:16];
          3'd2:    sio_out_d = byte_addr_d[15:12];
          3'd3:    sio_out_d = byte_addr_d[11:8];
          3'd4:    sio_out_d = byte_addr_d[7:4];
          default: sio_out_d = byte_addr_d[3:0];
        endcase
      end
      ST_DUMMY: begin
        cs_n_d   = 1'b0;
        sck_en_d = 1'b1;
      end
      ST_DATA: begin
        cs_n_d   = 1'b0;
        sck_en_d = 1'b1;
        vld_d    = 1'b1;
      end
      ST_PAUSE: cs_n_d = 1'b0;
      default: ;
    endcase
  end

  assign o_fetch_pc    = pc_q;
  assign o_sqi_cs_n    = cs_n_q;
  assign o_sqi_sck_en  = sck_en_q;
  assign o_sqi_sio_oe  = oe_q;
  assign o_sqi_sio_out = sio_out_q;
  assign o_dcd_enc_vld = vld_q;
  // Memory nibble flows straight through to the decoder while streaming
  assign o_dcd_enc     = vld_q ? i_sqi_sio_in : '0;

endmodule

// File: doc/idli_fetch_ctrl_m.md
# idli_fetch_ctrl_m

Instruction fetch sequencer between the SQI (quad-SPI) instruction memory and the instruction decoder. Issues the SQI READ command, 24-bit address and dummy cycles, then streams 16-bit instructions as 4-bit nibbles to the decoder with a valid strobe. Tracks the fetch PC, handles redirects (branches) and backend stalls, and only changes stream at instruction boundaries. The decoder therefore always sees four contiguous valid nibbles per instruction.

## Interface
- No parameters.
- i_dcd_gck  in  1  core clock.
- i_dcd_rst_n  in  1  reset, asynchronous, active-low.
- i_fetch_redirect  in  1  request to restart fetch at i_fetch_pc.
- i_fetch_pc  in  16  target instruction (16b word) address, sampled with redirect.
- i_fetch_stall  in  1  backend cannot accept a new instruction.
- o_fetch_pc  out  16  word address of the instruction being, or next to be, delivered.
- o_sqi_cs_n  out  1  memory chip select, active-low.
- o_sqi_sck_en  out  1  SQI clock gate enable.
- o_sqi_sio_out  out  4  nibble driven to memory.
- o_sqi_sio_oe  out  1  output enable for o_sqi_sio_out.
- i_sqi_sio_in  in  4  nibble returned by memory.
- o_dcd_enc  out  4  instruction nibble to decoder, MSB nibble first.
- o_dcd_enc_vld  out  1  o_dcd_enc valid.

## Operation
- States: IDLE, GAP, CMD, ADDR, DUMMY, DATA, PAUSE.
- Counters: 3b sequence counter for CMD/ADDR/DUMMY and 2b nibble counter for DATA.
- Pending-redirect flag plus a 16b pending PC register.
- Outputs are Moore, decoded from registered state. The one exception: o_dcd_enc is i_sqi_sio_in passed through combinationally in DATA.
- **IDLE**
  - cs_n=1, sck_en=0, oe=0.
  - On redirect: load PC, go to CMD.
- **CMD** (2 cycles)
  - cs_n=0, sck_en=1, oe=1.
  - Drives 0x0 then 0x3 (READ 0x03).
- **ADDR** (6 cycles)
  - oe=1.
  - Drives byte address {7'b0, pc, 1'b0}, most significant nibble first.
- **DUMMY** (2 cycles)
  - oe=0, sio_out=0, sck_en=1.
- **DATA**
  - oe=0, sck_en=1, vld=1.
  - The nibble counter advances every cycle.
  - On nibble 3 (last):
    - PC increments mod 2^16.
    - Redirect pending or asserted: go to GAP and load the new PC. The increment is suppressed.
    - Else if i_fetch_stall: go to PAUSE.
    - Else: remain in DATA for the next instruction.
- **Redirect during DATA nibbles 0-2**
  - Latched as pending, with the newest PC winning.
  - Taken after nibble 3. The current instruction always completes.
- **PAUSE**
  - cs_n=0, sck_en=0, vld=0. The memory holds its position with the clock stopped.
  - Stall low: return to DATA with the nibble counter at 0.
  - Redirect: go to GAP (redirect has priority over stall).
- **GAP** (1 cycle)
  - cs_n=1, sck_en=0, oe=0. Ends the transaction.
  - Then goes to CMD with the latched PC.
  - A redirect seen in GAP overwrites the PC; still exactly one GAP cycle.
- **Redirect in CMD/ADDR/DUMMY**: go to GAP next cycle, load the new PC, restart.
- **Wrap-around**: PC 0xFFFF→0x0000. Byte address 0x1FFFE is followed by the memory's own sequential wrap to 0, so the stream continues without a redirect.
- o_dcd_enc_vld=0 in every state other than DATA. o_dcd_enc is 0 when not valid.

## Timing
- Reset (async) values:
  - State IDLE, o_fetch_pc=0, pending flag=0.
  - o_sqi_cs_n=1, o_sqi_sck_en=0, o_sqi_sio_oe=0, o_sqi_sio_out=0.
  - o_dcd_enc=0, o_dcd_enc_vld=0.
- Reset mid-transaction: cs_n rises immediately (asynchronously) and any pending redirect is lost.
- Redirect latency from IDLE, redirect sampled at edge T:
  - CMD in cycles T+1..T+2.
  - ADDR in T+3..T+8.
  - DUMMY in T+9..T+10.
  - First valid nibble in T+11.
- From an active state add 1 GAP cycle, giving first nibble at T+12.
- Steady-state throughput: one instruction per 4 cycles, with vld continuously high.
- Stall is only sampled on nibble 3. Stall deasserted at edge S gives the next nibble 0 in cycle S+1.
- Simultaneous redirect + stall on nibble 3: redirect wins, go to GAP.

## Test plan
- Reset, then redirect PC=0x1234 → CMD nibbles 0,3; ADDR nibbles 0,0,2,4,6,8; 2 dummy cycles; vld high from cycle T+11; o_fetch_pc becomes 0x1235 after the 4th nibble.
- Continuous stream of 3 instructions → vld high for 12 consecutive cycles, PC +3, cs_n stays low throughout.
- Stall asserted on nibble 1, released 5 cycles later → current instruction completes; PAUSE with sck_en=0 and vld=0; resumes with nibble 0; no nibble lost or duplicated.
- Redirect to 0x0040 on nibble 1, redirect to 0x0080 on nibble 2 → instruction completes; one GAP cycle; ADDR drives byte address 0x000100; PC=0x0080 with no increment.
- Redirect during ADDR cycle 3 → GAP next cycle, then the full CMD/ADDR sequence with the new address.
- PC=0xFFFF streaming → after 4 nibbles PC=0x0000, cs_n stays low; async reset asserted mid-DATA → cs_n=1 and vld=0 immediately, state IDLE.
